// File: rtl/pipe_cpu_core.sv
// Five-stage IF/ID/EX/MEM/WB core with operand forwarding, load-use stall,
// branch resolution and flush in EX, HALT, and a per-cycle retire trace.
module pipe_cpu_core #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_re,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               retire_valid,
  output logic [3:0]         retire_rd,
  output logic [DATA_W-1:0]  retire_data,
  output logic               halted
);

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5, OP_SLT = 4'h6, OP_LDI = 4'h7, OP_LW = 4'h8;
  localparam logic [3:0] OP_SW = 4'h9, OP_BEQ = 4'hA, OP_HALT = 4'hB;

  function automatic logic [3:0] dest_of(input logic [15:0] ins);
    return (ins[15:12] >= OP_ADD && ins[15:12] <= OP_LW) ? ins[3:0] : 4'h0;
  endfunction

  function automatic logic reads_rs(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_SLT) || op == OP_LW || op == OP_SW || op == OP_BEQ;
  endfunction

  function automatic logic reads_rt(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_SLT) || op == OP_SW || op == OP_BEQ;
  endfunction

  logic [PC_W-1:0]   pc_r, ifid_pc_r, idex_pc_r;
  logic              ifid_valid_r, idex_valid_r, exmem_valid_r, memwb_valid_r;
  logic [15:0]       ifid_instr_r, idex_instr_r;
  logic [DATA_W-1:0] idex_a_r, idex_b_r, exmem_res_r, exmem_sdata_r, memwb_data_r;
  logic [3:0]        exmem_op_r, exmem_rd_r, memwb_rd_r;
  logic              memwb_halt_r, freeze_r, halted_r;
  logic [DATA_W-1:0] rf_r [16];

  logic [3:0]        id_op_s, id_rs_s, id_rt_s, ex_op_s, ex_rs_s, ex_rt_s, ex_rd_s;
  logic [DATA_W-1:0] id_a_s, id_b_s, ex_a_s, ex_b_s, ex_res_s;
  logic [PC_W-1:0]   ex_target_s;
  logic              wb_we_s, ex_taken_s, ex_halt_s, flush_s, stall_s;

  assign id_op_s = ifid_instr_r[15:12];
  assign id_rs_s = ifid_instr_r[11:8];
  assign id_rt_s = ifid_instr_r[7:4];
  assign ex_op_s = idex_instr_r[15:12];
  assign ex_rs_s = idex_instr_r[11:8];
  assign ex_rt_s = idex_instr_r[7:4];
  assign ex_rd_s = dest_of(idex_instr_r);
  assign wb_we_s = memwb_valid_r && (memwb_rd_r != 4'h0);

  // Register read; the WB write is visible in the same cycle
  always_comb begin
    if (id_rs_s == 4'h0) id_a_s = '0;
    else if (wb_we_s && memwb_rd_r == id_rs_s) id_a_s = memwb_data_r;
    else id_a_s = rf_r[id_rs_s];
    if (id_rt_s == 4'h0) id_b_s = '0;
    else if (wb_we_s && memwb_rd_r == id_rt_s) id_b_s = memwb_data_r;
    else id_b_s = rf_r[id_rt_s];
  end

  // Operand forwarding: EX/MEM beats MEM/WB beats the value read in ID
  always_comb begin
    if (exmem_rd_r != 4'h0 && exmem_rd_r == ex_rs_s) ex_a_s = exmem_res_r;
    else if (wb_we_s && memwb_rd_r == ex_rs_s) ex_a_s = memwb_data_r;
    else ex_a_s = idex_a_r;
    if (exmem_rd_r != 4'h0 && exmem_rd_r == ex_rt_s) ex_b_s = exmem_res_r;
    else if (wb_we_s && memwb_rd_r == ex_rt_s) ex_b_s = memwb_data_r;
    else ex_b_s = idex_b_r;
  end

  // ALU, immediate and address generation
  always_comb begin
    ex_res_s = '0;
    case (ex_op_s)
      OP_ADD:  ex_res_s = ex_a_s + ex_b_s;
      OP_SUB:  ex_res_s = ex_a_s - ex_b_s;
      OP_AND:  ex_res_s = ex_a_s & ex_b_s;
      OP_OR:   ex_res_s = ex_a_s | ex_b_s;
      OP_XOR:  ex_res_s = ex_a_s ^ ex_b_s;
      OP_SLT:  ex_res_s = ($signed(ex_a_s) < $signed(ex_b_s)) ? DATA_W'(1'b1) : '0;
      OP_LDI:  ex_res_s = DATA_W'($signed(idex_instr_r[11:4]));
      OP_LW:   ex_res_s = ex_a_s + DATA_W'($signed(idex_instr_r[7:4]));
      OP_SW:   ex_res_s = ex_a_s + DATA_W'($signed(idex_instr_r[3:0]));
      default: ex_res_s = '0;
    endcase
  end

  assign ex_taken_s  = idex_valid_r && ex_op_s == OP_BEQ && ex_a_s == ex_b_s;
  assign ex_target_s = idex_pc_r + PC_W'(1'b1) + PC_W'($signed(idex_instr_r[3:0]));
  assign ex_halt_s   = idex_valid_r && ex_op_s == OP_HALT;
  assign flush_s     = ex_taken_s || ex_halt_s;
  // A load in EX holds back a consumer in ID for one cycle
  assign stall_s = idex_valid_r && ex_op_s == OP_LW && ex_rd_s != 4'h0 && ifid_valid_r &&
                   ((reads_rs(id_op_s) && id_rs_s == ex_rd_s) ||
                    (reads_rt(id_op_s) && id_rt_s == ex_rd_s));

  // PC and IF/ID register; HALT in EX freezes fetch until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r         <= '0;
      ifid_pc_r    <= '0;
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= 16'h0000;
      freeze_r     <= 1'b0;
    end else begin
      if (ex_halt_s) freeze_r <= 1'b1;
      if (ex_taken_s) begin
        pc_r         <= ex_target_s;
        ifid_valid_r <= 1'b0;
      end else if (ex_halt_s || freeze_r) begin
        ifid_valid_r <= 1'b0;
      end else if (!stall_s) begin
        pc_r         <= pc_r + PC_W'(1'b1);
        ifid_pc_r    <= pc_r;
        ifid_valid_r <= 1'b1;
        ifid_instr_r <= imem_rdata;
      end
    end
  end

  // ID/EX, EX/MEM and MEM/WB registers; opcodes C-F enter EX as bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_valid_r  <= 1'b0;
      idex_instr_r  <= 16'h0000;
      idex_pc_r     <= '0;
      idex_a_r      <= '0;
      idex_b_r      <= '0;
      exmem_valid_r <= 1'b0;
      exmem_op_r    <= 4'h0;
      exmem_rd_r    <= 4'h0;
      exmem_res_r   <= '0;
      exmem_sdata_r <= '0;
      memwb_valid_r <= 1'b0;
      memwb_halt_r  <= 1'b0;
      memwb_rd_r    <= 4'h0;
      memwb_data_r  <= '0;
      halted_r      <= 1'b0;
    end else begin
      if (flush_s || stall_s) begin
        idex_valid_r <= 1'b0;
      end else begin
        idex_valid_r <= ifid_valid_r && (id_op_s <= OP_HALT);
        idex_instr_r <= ifid_instr_r;
        idex_pc_r    <= ifid_pc_r;
        idex_a_r     <= id_a_s;
        idex_b_r     <= id_b_s;
      end
      exmem_valid_r <= idex_valid_r;
      exmem_op_r    <= ex_op_s;
      exmem_rd_r    <= idex_valid_r ? ex_rd_s : 4'h0;
      exmem_res_r   <= ex_res_s;
      exmem_sdata_r <= ex_b_s;
      memwb_valid_r <= exmem_valid_r;
      memwb_halt_r  <= exmem_valid_r && exmem_op_r == OP_HALT;
      memwb_rd_r    <= exmem_rd_r;
      if (exmem_rd_r == 4'h0) memwb_data_r <= '0;
      else if (exmem_op_r == OP_LW) memwb_data_r <= dmem_rdata;
      else memwb_data_r <= exmem_res_r;
      if (memwb_halt_r) halted_r <= 1'b1;
    end
  end

  // Register file write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf_r[i] <= '0;
    end else if (wb_we_s) begin
      rf_r[memwb_rd_r] <= memwb_data_r;
    end
  end

  assign imem_addr    = pc_r;
  assign dmem_addr    = exmem_res_r[DADDR_W-1:0];
  assign dmem_wdata   = exmem_sdata_r;
  assign dmem_re      = !reset && exmem_valid_r && exmem_op_r == OP_LW;
  assign dmem_we      = !reset && exmem_valid_r && exmem_op_r == OP_SW && !halted_r;
  assign retire_valid = !reset && memwb_valid_r && !halted_r;
  assign retire_rd    = retire_valid ? memwb_rd_r : 4'h0;
  assign retire_data  = retire_valid ? memwb_data_r : '0;
  assign halted       = halted_r || memwb_halt_r;

endmodule

// File: tb/tb_pipe_cpu_core.sv
// Bench for pipe_cpu_core: an instruction-level model predicts the retire and
// store streams; directed programs also pin cycle timing; a DATA_W=8 core checks wrap.
module tb_pipe_cpu_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  imem_addr, dmem_addr;
  logic [15:0] imem_rdata, dmem_wdata, dmem_rdata, retire_data;
  logic        dmem_re, dmem_we, retire_valid, halted;
  logic [3:0]  retire_rd;

  logic [7:0]  u8_iaddr, u8_daddr, u8_wdata, u8_rdata, u8_rdata_ret;
  logic [15:0] u8_irdata;
  logic        u8_re, u8_we, u8_rv, u8_halted;
  logic [3:0]  u8_rrd;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] dmem_init [256];
  logic [15:0] imem8 [256];
  logic [7:0]  dmem8 [256];
  logic        load_req = 1'b0;

  pipe_cpu_core dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .retire_data(retire_data), .halted(halted));

  pipe_cpu_core #(.DATA_W(8)) u8 (
    .clk(clk), .reset(reset), .imem_addr(u8_iaddr), .imem_rdata(u8_irdata),
    .dmem_addr(u8_daddr), .dmem_re(u8_re), .dmem_we(u8_we), .dmem_wdata(u8_wdata),
    .dmem_rdata(u8_rdata), .retire_valid(u8_rv), .retire_rd(u8_rrd),
    .retire_data(u8_rdata_ret), .halted(u8_halted));

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  assign u8_irdata  = imem8[u8_iaddr];
  assign u8_rdata   = dmem8[u8_daddr];

  always @(posedge clk) begin
    if (load_req) dmem <= dmem_init;
    else if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  always @(posedge clk) if (u8_we) dmem8[u8_daddr] <= u8_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  typedef struct packed { logic [3:0] rd; logic [15:0] d; } ret_t;
  typedef struct packed { logic [7:0] a; logic [15:0] d; } st_t;
  typedef struct packed { int cyc; logic [3:0] rd; logic [15:0] d; } rec_t;
  ret_t exp_ret [$];
  st_t  exp_st [$];
  rec_t rec [$];
  int total = 0, bad = 0, halt_cyc = -1, we_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Sequential instruction-set model: one instruction at a time, no pipeline
  task automatic model_run();
    logic [15:0] r [16];
    logic [15:0] mm [256];
    logic [15:0] ins, a, b, v, sum;
    logic [3:0]  op, rd;
    logic [7:0]  pc;
    logic        wr, done;
    exp_ret.delete();
    exp_st.delete();
    for (int i = 0; i < 16; i++) r[i] = 16'h0000;
    mm = dmem_init;
    pc = 8'h00;
    done = 1'b0;
    for (int step = 0; step < 1000 && !done; step++) begin
      ins = imem[pc];
      op = ins[15:12]; rd = ins[3:0];
      a = r[ins[11:8]]; b = r[ins[7:4]];
      pc = pc + 8'd1;
      wr = 1'b0; v = 16'h0000;
      case (op)
        4'h0: exp_ret.push_back({4'h0, 16'h0000});
        4'h1: begin v = a + b; wr = 1'b1; end
        4'h2: begin v = a - b; wr = 1'b1; end
        4'h3: begin v = a & b; wr = 1'b1; end
        4'h4: begin v = a | b; wr = 1'b1; end
        4'h5: begin v = a ^ b; wr = 1'b1; end
        4'h6: begin v = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; wr = 1'b1; end
        4'h7: begin v = {{8{ins[11]}}, ins[11:4]}; wr = 1'b1; end
        4'h8: begin sum = a + {{12{ins[7]}}, ins[7:4]}; v = mm[sum[7:0]]; wr = 1'b1; end
        4'h9: begin
          sum = a + {{12{ins[3]}}, ins[3:0]};
          exp_st.push_back({sum[7:0], b});
          mm[sum[7:0]] = b;
          exp_ret.push_back({4'h0, 16'h0000});
        end
        4'hA: begin
          exp_ret.push_back({4'h0, 16'h0000});
          if (a == b) pc = pc + {{4{ins[3]}}, ins[3:0]};
        end
        4'hB: begin exp_ret.push_back({4'h0, 16'h0000}); done = 1'b1; end
        default: ;
      endcase
      if (wr) begin
        if (rd != 4'h0) r[rd] = v;
        exp_ret.push_back({rd, (rd != 4'h0) ? v : 16'h0000});
      end
    end
  endtask

  task automatic prepare();
    @(posedge clk); #1;
    reset = 1'b1;
    load_req = 1'b1;
    model_run();
    rec.delete();
    halt_cyc = -1;
    @(posedge clk); #1;
    load_req = 1'b0;
    @(posedge clk); #1;
    check("reset_pc", 32'(imem_addr), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("halt_reached", 32'(halted), 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("halt_sticky", 32'(halted), 32'h1);
    check("retires_left", 32'(exp_ret.size()), 32'h0);
    check("stores_left", 32'(exp_st.size()), 32'h0);
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 256; k++) begin
      imem[k] = 16'hB000;
      dmem_init[k] = 16'($urandom);
    end
  endtask

  initial begin
    ret_t e;
    st_t  s;
    rec_t rr;
    int   sel;
    logic [3:0] op, rs, rt, rd;
    for (int k = 0; k < 256; k++) imem8[k] = 16'hB000;
    imem8[0] = 16'h77F1; imem8[1] = 16'h7012; imem8[2] = 16'h1123; imem8[3] = 16'h9030;

    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          total++;
          if (retire_valid !== 1'b0 || dmem_we !== 1'b0 || dmem_re !== 1'b0 ||
              u8_rv !== 1'b0 || u8_we !== 1'b0 || u8_re !== 1'b0) begin
            bad++;
            $display("FAIL reset_quiet: rv=%b we=%b re=%b u8 rv=%b we=%b re=%b, want all 0",
                     retire_valid, dmem_we, dmem_re, u8_rv, u8_we, u8_re);
          end
        end else begin
          if (retire_valid) begin
            total++;
            rr.cyc = cyc + 1; rr.rd = retire_rd; rr.d = retire_data;
            rec.push_back(rr);
            if (exp_ret.size() == 0) begin
              bad++;
              $display("FAIL retire_extra: got rd=%0d data=%0h want none", retire_rd, retire_data);
            end else begin
              e = exp_ret.pop_front();
              if (retire_rd !== e.rd || retire_data !== e.d) begin
                bad++;
                $display("FAIL retire: got rd=%0d data=%0h want rd=%0d data=%0h",
                         retire_rd, retire_data, e.rd, e.d);
              end
            end
          end
          if (dmem_we) begin
            total++;
            we_count++;
            if (exp_st.size() == 0) begin
              bad++;
              $display("FAIL store_extra: got addr=%0h data=%0h want none", dmem_addr, dmem_wdata);
            end else begin
              s = exp_st.pop_front();
              if (dmem_addr !== s.a || dmem_wdata !== s.d) begin
                bad++;
                $display("FAIL store: got addr=%0h data=%0h want addr=%0h data=%0h",
                         dmem_addr, dmem_wdata, s.a, s.d);
              end
            end
          end
          if (u8_we) begin
            total++;
            if (u8_daddr !== 8'h00 || u8_wdata !== 8'h80) begin
              bad++;
              $display("FAIL w8_store: got addr=%0h data=%0h want 0/80", u8_daddr, u8_wdata);
            end
          end
          if (u8_rv && u8_rrd == 4'd3) begin
            total++;
            if (u8_rdata_ret !== 8'h80) begin
              bad++;
              $display("FAIL w8_r3: got %0h want 80", u8_rdata_ret);
            end
          end
          if (halted && halt_cyc < 0) halt_cyc = cyc + 1;
        end
      end
    join_none

    // LDI/LDI/ADD/HALT: r3 = 2 in cycle 7, halted from cycle 8
    clear_prog();
    imem[0] = 16'h7051; imem[1] = 16'h7FD2; imem[2] = 16'h1123;
    prepare();
    check("t1_model_len", 32'(exp_ret.size()), 32'd4);
    check("t1_model_r3", 32'(exp_ret[2]), 32'h30002);
    run_to_halt(60);
    check("t1_count", 32'(rec.size()), 32'd4);
    check("t1_r3_cycle", 32'(rec[2].cyc), 32'd7);
    check("t1_r3", {12'h0, rec[2].rd, rec[2].d}, 32'h30002);
    check("t1_halt_cycle", 32'(halt_cyc), 32'd8);

    // Back-to-back dependents through EX/MEM forwarding
    clear_prog();
    imem[0] = 16'h7011;
    for (int k = 1; k < 5; k++) imem[k] = 16'h1111;
    prepare();
    run_to_halt(60);
    for (int i = 0; i < 5; i++) begin
      check("t2_cycle", 32'(rec[i].cyc), 32'(5 + i));
      check("t2_data", 32'(rec[i].d), 32'(1 << i));
    end

    // Load-use: one bubble, r3 = 0x2468
    clear_prog();
    dmem_init[4] = 16'h1234;
    imem[0] = 16'h7041; imem[1] = 16'h8102; imem[2] = 16'h1223;
    prepare();
    run_to_halt(60);
    check("t3_lw_cycle", 32'(rec[1].cyc), 32'd6);
    check("t3_add_cycle", 32'(rec[2].cyc), 32'd8);
    check("t3_r3", 32'(rec[2].d), 32'h2468);

    // Taken branch skips two instructions with two idle retire cycles
    clear_prog();
    imem[0] = 16'hA002; imem[1] = 16'h7015; imem[2] = 16'h7016; imem[3] = 16'h7097;
    prepare();
    run_to_halt(60);
    check("t4_count", 32'(rec.size()), 32'd3);
    check("t4_beq_cycle", 32'(rec[0].cyc), 32'd5);
    check("t4_r7_cycle", 32'(rec[1].cyc), 32'd8);
    check("t4_r7", {12'h0, rec[1].rd, rec[1].d}, 32'h70009);

    // Reset while SW is in EX: no write, restart from PC 0 with cleared registers
    clear_prog();
    imem[0] = 16'h1124; imem[1] = 16'h7051; imem[2] = 16'h7072;
    imem[3] = 16'h0000; imem[4] = 16'h0000; imem[5] = 16'h9010;
    prepare();
    we_count = 0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    check("t6_retired_before", 32'(rec.size()), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("t6_no_store", 32'(we_count), 32'd0);
    prepare();
    run_to_halt(60);
    check("t6_r4_zero", {12'h0, rec[0].rd, rec[0].d}, 32'h40000);
    check("t6_one_store", 32'(we_count), 32'd1);

    // Random programs, forward-only branches so every program ends at a HALT
    for (int t = 0; t < 40; t++) begin
      clear_prog();
      for (int k = 0; k < 24; k++) begin
        sel = $urandom_range(0, 19);
        rs = 4'($urandom_range(0, 7));
        rt = 4'($urandom_range(0, 7));
        rd = 4'($urandom_range(0, 7));
        if (sel < 7) op = 4'($urandom_range(1, 6));
        else if (sel < 10) begin op = 4'h7; rs = 4'($urandom); end
        else if (sel < 13) begin op = 4'h8; rt = 4'($urandom); end
        else if (sel < 15) op = 4'h9;
        else if (sel < 17) begin op = 4'hA; if (sel == 16) rt = rs; end
        else if (sel < 19) op = 4'h0;
        else op = 4'($urandom_range(12, 15));
        imem[k] = {op, rs, rt, rd};
      end
      prepare();
      run_to_halt(200);
    end

    check("w8_mem0", 32'(dmem8[0]), 32'h80);
    check("w8_halted", 32'(u8_halted), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_cpu_core.md
# pipe_cpu_core

Parametrised successor core to the 16-bit five-stage CPU: IF/ID/EX/MEM/WB pipeline with data width set by parameter. It adds full operand forwarding, load-use stall, a resolved branch with flush, HALT, and a retire trace port. Instruction and data memories sit outside the core behind combinational-read ports, so one core serves both the FPGA top and the testbench.

## Interface
- DATA_W, 16: register/ALU/data-memory word width; legal range 8 to 64.
- PC_W, 8: instruction address width; the PC wraps modulo 2^PC_W.
- DADDR_W, 8: data address width; the address is the low DADDR_W bits of the EX result.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_addr  out  PC_W  fetch address (current PC).
- imem_rdata  in  16  instruction at imem_addr, same cycle.
- dmem_addr  out  DADDR_W  load/store address.
- dmem_re  out  1  load in MEM this cycle.
- dmem_we  out  1  store in MEM this cycle; memory writes on the clk edge.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data for dmem_addr, same cycle.
- retire_valid  out  1  a non-bubble instruction is in WB this cycle.
- retire_rd  out  4  destination of the retiring instruction; 0 if none.
- retire_data  out  DATA_W  value written; 0 if none.
- halted  out  1  HALT has retired; sticky until reset.

## Operation
- Format: op[15:12], rs[11:8], rt[7:4], rd[3:0]. Sixteen registers; r0 reads 0 and writes to it are discarded.
- 0 NOP.
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs op rt.
- 6 SLT: rd = (signed rs < signed rt) ? 1 : 0.
- 7 LDI: rd = sext(instr[11:4]).
- 8 LW: rd = dmem[rs + sext(instr[7:4])].
- 9 SW: dmem[rs + sext(instr[3:0])] = rt.
- A BEQ: if rs == rt, then PC = PC_beq + 1 + sext(instr[3:0]).
- B HALT.
- C to F: treated as NOP and never retire.
- Arithmetic wraps modulo 2^DATA_W. Branch target wraps modulo 2^PC_W.
- Register file is write-first: a WB write is visible to the ID read in the same cycle.
- Forwarding to EX operands: the EX/MEM result has priority over the MEM/WB result, then the register file. There is no forwarding from r0 or from bubbles. SW store data uses the forwarded rt value.
- Load-use stall: triggered when ID/EX holds LW with rd != 0, and the ID instruction reads that rd (rs for ALU ops, LW, SW, BEQ; rt for ALU ops, SW, BEQ). Effect for one cycle: PC and IF/ID hold, and a bubble enters ID/EX.
- BEQ resolves in EX. If taken, the PC loads the target and IF/ID and ID/EX become bubbles (2-cycle penalty). Not taken has no penalty.
- HALT in EX: flushes IF/ID and ID/EX and freezes the PC. Older instructions drain normally. halted rises in the cycle HALT occupies WB.
- A HALT fetched in the shadow of a taken branch is flushed and has no effect.
- After halted, the core stays idle: dmem_we = 0, retire_valid = 0.

## Timing
- Reset state (next edge with reset high): PC = 0, all pipeline registers are bubbles, all registers = 0, halted = 0.
- Outputs during and after reset: retire_valid = 0, dmem_we = 0, dmem_re = 0. imem_addr = 0 until the first fetch advances.
- dmem_we and dmem_re are gated by !reset, so an in-flight SW never writes during a reset cycle.
- Latency: an instruction fetched in cycle n is in WB in cycle n+4, plus stalls. CPI is 1 without hazards.
- A load-use stall costs 1 cycle; a taken BEQ costs 2 cycles.
- Load-use and taken-branch cannot coincide (both need the EX slot); no arbitration is needed.
- A stall in the same cycle as a WB write still commits the WB write.
- A reset asserted mid-program discards all in-flight work on the reset edge; fetch restarts at PC 0.

## Test plan
- Reset, then program LDI r1,5; LDI r2,-3; ADD r3,r1,r2; HALT -> r3 retires with value 2 in cycle 7 after reset release, no stalls; halted is high one cycle later and stays high.
- Back-to-back dependents: LDI r1,1; ADD r1,r1,r1 ×4 -> retire_data sequence 1, 2, 4, 8, 16 on consecutive cycles (EX/MEM forwarding path).
- dmem[4] = 0x1234, then LDI r1,4; LW r2,0(r1); ADD r3,r2,r2 -> exactly one bubble cycle; r3 = 0x2468.
- Taken branch: BEQ r0,r0,+2 followed by LDI r5,1; LDI r6,1; LDI r7,9 -> r5 and r6 never retire; r7 = 9; two idle retire cycles.
- SW forwarding and wrap, with DATA_W = 8: LDI r1,0x7F; LDI r2,1; ADD r3,r1,r2; SW r3,0(r0) -> dmem[0] = 0x80.
- Reset asserted while SW is in EX -> no dmem_we pulse; after release, execution restarts at PC 0 with all registers reading 0.
